// File: rtl/sseg_scan_ctrl_if.sv
// IOBUS slice seen by the seven-segment scan controller: address, write data/strobe, read-back.
// Purely combinational bundle; no latency of its own.
// No backpressure: the MCU bus writes in one cycle and reads combinationally.
interface sseg_scan_ctrl_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] rd_data;
  logic        rd_hit;

  // MCU side drives the bus and samples the read-back mux
  modport master (
    output IOBUS_ADDR,
    output IOBUS_OUT,
    output IOBUS_WR,
    input  rd_data,
    input  rd_hit
  );

  // Peripheral side decodes the bus and returns register contents
  modport slave (
    input  IOBUS_ADDR,
    input  IOBUS_OUT,
    input  IOBUS_WR,
    output rd_data,
    output rd_hit
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Basys3 4-digit seven-segment scan controller with data/control registers on the IOBUS.
// Register writes land on the write edge; segs/an are registered and reflect a write one edge later.
// No backpressure: writes always accepted, read-back is combinational.
module sseg_scan_ctrl #(
  parameter logic [31:0] DATA_ADDR = 32'h1100C014,
  parameter logic [31:0] CTRL_ADDR = 32'h1100C018,
  parameter int          PRESCALE  = 50000,
  parameter int          GAP       = 2
) (
  input  logic                CLK,
  input  logic                RESET_N,
  sseg_scan_ctrl_if.slave     bus,
  output logic [7:0]          segs,
  output logic [3:0]          an
);

  // Counter only has to reach the longer of the two phase lengths minus one
  localparam int CNT_MAX = (PRESCALE > GAP) ? PRESCALE : GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] DRV_LAST = CNT_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  logic [15:0]      r_data;
  logic [7:0]       r_ctrl;
  state_t           state, state_n;
  logic [1:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       segs_n;
  logic [3:0]       an_n;

  logic       data_sel, ctrl_sel;
  logic       en, lzb;
  logic [3:0] dp;
  logic [3:0] nib;
  logic       blank;
  logic       unused_wr_hi;

  assign data_sel = (bus.IOBUS_ADDR == DATA_ADDR);
  assign ctrl_sel = (bus.IOBUS_ADDR == CTRL_ADDR);
  assign en       = r_ctrl[0];
  assign lzb      = r_ctrl[1];
  assign dp       = r_ctrl[7:4];

  // Upper write-data bits are architecturally ignored
  assign unused_wr_hi = ^bus.IOBUS_OUT[31:16];

  // Active-low segment pattern g..a for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [7:0] v;
    case (n)
      4'h0: v = 8'hC0;  4'h1: v = 8'hF9;  4'h2: v = 8'hA4;  4'h3: v = 8'hB0;
      4'h4: v = 8'h99;  4'h5: v = 8'h92;  4'h6: v = 8'h82;  4'h7: v = 8'hF8;
      4'h8: v = 8'h80;  4'h9: v = 8'h90;  4'hA: v = 8'h88;  4'hB: v = 8'h83;
      4'hC: v = 8'hC6;  4'hD: v = 8'hA1;  4'hE: v = 8'h86;  default: v = 8'h8E;
    endcase
    return v[6:0];
  endfunction

  // Software-visible registers: data and control, loaded on a matching write
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_data <= 16'h0000;
      r_ctrl <= 8'h00;
    end else if (bus.IOBUS_WR) begin
      if (data_sel) r_data <= bus.IOBUS_OUT[15:0];
      if (ctrl_sel) r_ctrl <= bus.IOBUS_OUT[7:0];
    end
  end

  // Read-back mux; unmapped addresses return zero and no hit
  always_comb begin
    bus.rd_data = 32'h0000_0000;
    bus.rd_hit  = 1'b0;
    if (data_sel) begin
      bus.rd_data = {16'h0000, r_data};
      bus.rd_hit  = 1'b1;
    end else if (ctrl_sel) begin
      bus.rd_data = {24'h000000, r_ctrl};
      bus.rd_hit  = 1'b1;
    end
  end

  // Scan sequencer next state: IDLE -> BLANK(GAP) -> DRIVE(PRESCALE) -> BLANK ..., EN=0 wins
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    if (!en) begin
      state_n = ST_IDLE;
      idx_n   = 2'd0;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_BLANK;
          idx_n   = 2'd0;
          cnt_n   = '0;
        end
        ST_BLANK: begin
          if (cnt == GAP_LAST) begin
            state_n = ST_DRIVE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt == DRV_LAST) begin
            state_n = ST_BLANK;
            idx_n   = idx + 2'd1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          idx_n   = 2'd0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Output pattern for the state being entered, using the live registers
  always_comb begin
    nib = r_data[{idx_n, 2'b00} +: 4];
    case (idx_n)
      2'd1:    blank = lzb && (r_data[15:4]  == 12'h000);
      2'd2:    blank = lzb && (r_data[15:8]  == 8'h00);
      2'd3:    blank = lzb && (r_data[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    an_n   = 4'hF;
    segs_n = 8'hFF;
    if (state_n == ST_DRIVE) begin
      segs_n = {~dp[idx_n], hex7(nib)};
      if (!blank) an_n = ~(4'b0001 << idx_n);
    end
  end

  // Sequencer state and registered display outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      idx   <= 2'd0;
      cnt   <= '0;
      an    <= 4'hF;
      segs  <= 8'hFF;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      an    <= an_n;
      segs  <= segs_n;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: directed walk-through of the display behaviours plus random bus traffic.
// Reference model tracks elapsed scan time since enable and derives digit/slot arithmetically.
// Every edge compares an/segs; every cycle compares the read-back mux.
module tb_sseg_scan_ctrl;
  localparam int P = 4;
  localparam int G = 1;
  localparam logic [31:0] DA = 32'h1100C014;
  localparam logic [31:0] CA = 32'h1100C018;
  localparam logic [31:0] OA = 32'h1100C000;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [7:0] segs;
  logic [3:0] an;

  sseg_scan_ctrl_if bus();

  sseg_scan_ctrl #(
    .DATA_ADDR(DA),
    .CTRL_ADDR(CA),
    .PRESCALE (P),
    .GAP      (G)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus),
    .segs   (segs),
    .an     (an)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_data;
  logic [7:0]  m_ctrl;
  bit          m_run;
  int          m_t;
  int          cur_dig;
  int          cur_slot;
  logic [7:0]  e_segs;
  logic [3:0]  e_an;
  logic [7:0]  hex_tab [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a == DA) return {16'h0, m_data};
    if (a == CA) return {24'h0, m_ctrl};
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_data = 16'h0; m_ctrl = 8'h0; m_run = 0; m_t = 0; cur_dig = -1; cur_slot = -1;
  endtask

  // One clock edge of the reference: outputs from pre-edge registers, then apply the write
  task automatic model_edge();
    logic [3:0] nib;
    bit blank;
    e_an = 4'hF; e_segs = 8'hFF; cur_dig = -1; cur_slot = -1;
    if (!m_ctrl[0]) begin
      m_run = 0;
    end else begin
      if (!m_run) begin m_run = 1; m_t = 0; end
      else m_t++;
      cur_slot = m_t % (G + P);
      cur_dig  = (m_t / (G + P)) % 4;
      if (cur_slot >= G) begin
        nib    = 4'((m_data >> (4 * cur_dig)) & 16'hF);
        e_segs = {~m_ctrl[4 + cur_dig], hex_tab[nib][6:0]};
        blank  = m_ctrl[1] && (cur_dig != 0) && ((m_data >> (4 * cur_dig)) == 16'h0);
        e_an   = blank ? 4'hF : ~(4'b0001 << cur_dig);
      end
    end
    if (bus.IOBUS_WR && bus.IOBUS_ADDR == DA) m_data = bus.IOBUS_OUT[15:0];
    if (bus.IOBUS_WR && bus.IOBUS_ADDR == CA) m_ctrl = bus.IOBUS_OUT[7:0];
  endtask

  // Drive one bus cycle, check read-back before the edge and display after it
  task automatic tick(input logic wr, input logic [31:0] addr, input logic [31:0] dat);
    bus.IOBUS_WR = wr; bus.IOBUS_ADDR = addr; bus.IOBUS_OUT = dat;
    #1;
    check_eq("rd_data", bus.rd_data, model_rd(addr));
    check_eq("rd_hit", {31'h0, bus.rd_hit}, {31'h0, (addr == DA) || (addr == CA)});
    @(posedge CLK);
    model_edge();
    #1;
    check_eq("an", {28'h0, an}, {28'h0, e_an});
    check_eq("segs", {24'h0, segs}, {24'h0, e_segs});
  endtask

  task automatic idle(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0: a = DA;
        1: a = CA;
        default: a = OA;
      endcase
      tick(1'b0, a, $urandom);
    end
  endtask

  // Advance until the first DRIVE edge of digit d has just been applied
  task automatic wait_drive(input int d);
    for (int i = 0; i < 200; i++) begin
      if (m_run && cur_dig == d && cur_slot == G) return;
      tick(1'b0, DA, 32'h0);
    end
    checks++; failures++;
    $display("FAIL wait_drive timeout digit=%0d got=none exp=drive", d);
  endtask

  initial begin
    logic [31:0] v;
    int r;
    hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    model_reset();
    RESET_N = 1'b0;
    bus.IOBUS_WR = 1'b0; bus.IOBUS_ADDR = DA; bus.IOBUS_OUT = 32'h0;

    // Reset state
    #12;
    check_eq("rst_an", {28'h0, an}, 32'hF);
    check_eq("rst_segs", {24'h0, segs}, 32'hFF);
    check_eq("rst_rd_data", bus.rd_data, 32'h0);
    bus.IOBUS_ADDR = OA;
    #1;
    check_eq("rst_rd_hit", {31'h0, bus.rd_hit}, 32'h0);
    RESET_N = 1'b1;

    // Basic scan of 12AF
    tick(1'b1, DA, 32'hFFFF_12AF);
    tick(1'b1, CA, 32'h0000_0001);
    idle(2 * 4 * (G + P) + 3);
    wait_drive(0);
    check_eq("scan_d0_segs", {24'h0, segs}, 32'h8E);
    wait_drive(3);
    check_eq("scan_d3_an", {28'h0, an}, 32'h7);
    check_eq("scan_d3_segs", {24'h0, segs}, 32'hF9);

    // Leading-zero blanking
    tick(1'b1, DA, 32'h0000_0005);
    tick(1'b1, CA, 32'h0000_0003);
    wait_drive(0);
    check_eq("lzb_d0_an", {28'h0, an}, 32'hE);
    check_eq("lzb_d0_segs", {24'h0, segs}, 32'h92);
    wait_drive(2);
    check_eq("lzb_d2_an", {28'h0, an}, 32'hF);
    tick(1'b1, CA, 32'h0000_0001);
    wait_drive(3);
    check_eq("nolzb_d3_an", {28'h0, an}, 32'h7);
    check_eq("nolzb_d3_segs", {24'h0, segs}, 32'hC0);

    // Decimal point and live data update during a DRIVE slot
    tick(1'b1, CA, 32'h0000_0021);
    tick(1'b1, DA, 32'h0000_0000);
    wait_drive(1);
    check_eq("dp_d1_segs", {24'h0, segs}, 32'h40);
    tick(1'b1, DA, 32'h0000_0080);
    tick(1'b0, DA, 32'h0);
    check_eq("live_d1_segs", {24'h0, segs}, 32'h00);
    check_eq("live_d1_an", {28'h0, an}, 32'hD);

    // Disable in the middle of digit 2, then re-enable from digit 0
    wait_drive(2);
    tick(1'b1, CA, 32'h0000_0000);
    tick(1'b0, CA, 32'h0);
    check_eq("dis_an", {28'h0, an}, 32'hF);
    idle(5);
    tick(1'b1, CA, 32'h0000_0001);
    tick(1'b0, CA, 32'h0);
    check_eq("reen_blank_an", {28'h0, an}, 32'hF);
    tick(1'b0, CA, 32'h0);
    check_eq("reen_d0_an", {28'h0, an}, 32'hE);

    // Read-back, then asynchronous reset mid-cycle during a DRIVE slot
    tick(1'b1, CA, 32'hFFFF_FFFF);
    bus.IOBUS_WR = 1'b0; bus.IOBUS_ADDR = CA;
    #1;
    check_eq("rb_ctrl", bus.rd_data, 32'h0000_00FF);
    wait_drive(0);
    #3;
    RESET_N = 1'b0;
    #1;
    check_eq("arst_an", {28'h0, an}, 32'hF);
    check_eq("arst_segs", {24'h0, segs}, 32'hFF);
    check_eq("arst_rd", bus.rd_data, 32'h0);
    model_reset();
    #2;
    RESET_N = 1'b1;

    // Random bus traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      v = $urandom;
      if (r < 8) begin
        tick(1'b1, DA, v);
      end else if (r < 12) begin
        if ($urandom_range(0, 9) != 0) v[0] = 1'b1;
        tick(1'b1, CA, v);
      end else if (r < 15) begin
        tick(1'b1, ($urandom_range(0, 1) != 0) ? OA : (DA + 32'd8), v);
      end else begin
        idle(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
